// File: rtl/boot_load_ctrl.sv
// rtl/boot_load_ctrl.sv - CPU run / UART program-load sequencer with reset ownership and write steering
module boot_load_ctrl #(
  parameter int ADDR_W         = 15,
  parameter int CNT_W          = 14,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DRAIN_CYCLES   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_pg_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic              upg_done_i,
  output logic              upg_rst_o,
  output logic              cpu_rst_o,
  output logic              rom_wen_o,
  output logic              ram_wen_o,
  output logic [CNT_W-1:0]  rom_words_o,
  output logic [CNT_W-1:0]  ram_words_o,
  output logic              load_busy_o,
  output logic              err_timeout_o
);

  localparam int IDLE_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  // Idle value one short of the limit: the increment made this cycle would reach it.
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_DRAIN,
    ST_RUN,
    ST_ARM,
    ST_LOAD
  } state_t;

  state_t              state_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [CNT_W-1:0]    rom_words_q, rom_words_d;
  logic [CNT_W-1:0]    ram_words_q, ram_words_d;
  logic                upg_rst_q;
  logic                cpu_rst_q;
  logic                load_busy_q;
  logic                err_timeout_q;

  logic                loading;
  logic                tgt_ram;
  logic                rom_wen;
  logic                ram_wen;
  logic                unused_adr;

  assign loading    = (state_q == ST_ARM) || (state_q == ST_LOAD);
  assign tgt_ram    = upg_adr_i[ADDR_W-1];
  assign rom_wen    = upg_wen_i & ~tgt_ram & loading;
  assign ram_wen    = upg_wen_i &  tgt_ram & loading;
  assign unused_adr = ^upg_adr_i[ADDR_W-2:0];

  always_comb begin
    rom_words_d = rom_words_q;
    ram_words_d = ram_words_q;
    if (rom_wen && (rom_words_q != CNT_MAX)) rom_words_d = rom_words_q + CNT_W'(1);
    if (ram_wen && (ram_words_q != CNT_MAX)) ram_words_d = ram_words_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_DRAIN;
      drain_q       <= '0;
      idle_q        <= '0;
      rom_words_q   <= '0;
      ram_words_q   <= '0;
      upg_rst_q     <= 1'b1;
      cpu_rst_q     <= 1'b1;
      load_busy_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      rom_words_q <= rom_words_d;
      ram_words_q <= ram_words_d;
      case (state_q)
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        ST_RUN: begin
          if (start_pg_i) begin
            state_q       <= ST_ARM;
            upg_rst_q     <= 1'b0;
            cpu_rst_q     <= 1'b1;
            load_busy_q   <= 1'b1;
            rom_words_q   <= '0;
            ram_words_q   <= '0;
            err_timeout_q <= 1'b0;
            idle_q        <= '0;
          end
        end
        ST_ARM, ST_LOAD: begin
          if (upg_wen_i) begin
            idle_q  <= '0;
            state_q <= ST_LOAD;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
          // Done takes priority over the timeout; a write in the limit cycle suppresses it.
          if (upg_done_i || (!upg_wen_i && (idle_q == IDLE_LAST))) begin
            state_q     <= ST_DRAIN;
            drain_q     <= '0;
            upg_rst_q   <= 1'b1;
            cpu_rst_q   <= 1'b1;
            load_busy_q <= 1'b0;
            if (!upg_done_i) err_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_DRAIN;
          drain_q <= '0;
        end
      endcase
    end
  end

  assign upg_rst_o     = upg_rst_q;
  assign cpu_rst_o     = cpu_rst_q;
  assign load_busy_o   = load_busy_q;
  assign err_timeout_o = err_timeout_q;
  assign rom_words_o   = rom_words_q;
  assign ram_words_o   = ram_words_q;
  assign rom_wen_o     = rom_wen;
  assign ram_wen_o     = ram_wen;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// tb/tb_boot_load_ctrl.sv - bench for boot_load_ctrl against a cycle-level load/drain model
module tb_boot_load_ctrl;

  localparam int ADDR_W = 15;
  localparam int CNT_W  = 4;
  localparam int TMO    = 50;
  localparam int DRN    = 16;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_pg, upg_wen, upg_done;
  logic [ADDR_W-1:0] upg_adr;
  logic              upg_rst, cpu_rst, rom_wen, ram_wen, load_busy, err_timeout;
  logic [CNT_W-1:0]  rom_words, ram_words;

  int checks   = 0;
  int failures = 0;

  // Model: a load is either in progress or not; otherwise count down remaining CPU-reset cycles.
  bit m_loading;
  int m_drain, m_idle, m_rom, m_ram;
  bit m_err;
  bit smp_rom_wen, smp_ram_wen, exp_rom_wen, exp_ram_wen;

  always #5 clk = ~clk;

  boot_load_ctrl #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_pg_i(start_pg), .upg_wen_i(upg_wen),
    .upg_adr_i(upg_adr), .upg_done_i(upg_done), .upg_rst_o(upg_rst), .cpu_rst_o(cpu_rst),
    .rom_wen_o(rom_wen), .ram_wen_o(ram_wen), .rom_words_o(rom_words), .ram_words_o(ram_words),
    .load_busy_o(load_busy), .err_timeout_o(err_timeout)
  );

  task automatic model_reset();
    m_loading = 0; m_drain = DRN; m_idle = 0; m_rom = 0; m_ram = 0; m_err = 0;
  endtask

  task automatic step(input bit s, input bit w, input logic [ADDR_W-1:0] a, input bit d);
    start_pg = s; upg_wen = w; upg_adr = a; upg_done = d;
    #1;
    smp_rom_wen = rom_wen;
    smp_ram_wen = ram_wen;
    exp_rom_wen = m_loading && w && !a[ADDR_W-1];
    exp_ram_wen = m_loading && w && a[ADDR_W-1];
    @(posedge clk);
    if (m_loading) begin
      if (w) begin
        if (a[ADDR_W-1]) m_ram = (m_ram < MAXC) ? m_ram + 1 : m_ram;
        else             m_rom = (m_rom < MAXC) ? m_rom + 1 : m_rom;
        m_idle = 0;
      end else begin
        m_idle++;
      end
      if (d) begin
        m_loading = 0; m_drain = DRN;
      end else if (!w && m_idle == TMO - 1) begin
        m_loading = 0; m_drain = DRN; m_err = 1;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (s) begin
      m_loading = 1; m_rom = 0; m_ram = 0; m_err = 0; m_idle = 0;
    end
    #1;
    start_pg = 0; upg_wen = 0; upg_done = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (upg_rst !== 1'b1) begin failures++; $display("FAIL rst_upg_rst got=%b want=1", upg_rst); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst got=%b want=1", cpu_rst); end
    checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", load_busy); end
    checks++; if (rom_words !== '0 || ram_words !== '0) begin failures++; $display("FAIL rst_words got=%0d/%0d want=0/0", rom_words, ram_words); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err_timeout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DRN; i++) begin
      step(1'($urandom), 1'($urandom), ADDR_W'($urandom), 1'($urandom));
      checks++; if (cpu_rst !== (i < DRN - 1)) begin failures++; $display("FAIL drain_cpu_rst cyc=%0d got=%b want=%b", i, cpu_rst, i < DRN - 1); end
      checks++; if (upg_rst !== 1'b1) begin failures++; $display("FAIL drain_upg_rst cyc=%0d got=%b want=1", i, upg_rst); end
      checks++; if (smp_rom_wen || smp_ram_wen) begin failures++; $display("FAIL drain_wen cyc=%0d got=%b%b want=00", i, smp_rom_wen, smp_ram_wen); end
    end
    checks++; if (rom_words !== '0 || ram_words !== '0) begin failures++; $display("FAIL drain_words got=%0d/%0d want=0/0", rom_words, ram_words); end
  endtask

  task automatic test_basic_load();
    int rp = 0, mp = 0;
    step(1, 0, '0, 0);
    checks++; if (upg_rst !== 1'b0 || cpu_rst !== 1'b1 || load_busy !== 1'b1) begin failures++; $display("FAIL arm_entry got upg=%b cpu=%b busy=%b want 0 1 1", upg_rst, cpu_rst, load_busy); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ADDR_W'(i), 0);
      rp += int'(smp_rom_wen); mp += int'(smp_ram_wen);
      checks++; if (upg_rst !== 1'b0) begin failures++; $display("FAIL load_upg_rst got=%b want=0", upg_rst); end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, ADDR_W'(16'h4000 + i), 0);
      rp += int'(smp_rom_wen); mp += int'(smp_ram_wen);
    end
    step(0, 0, '0, 1);
    checks++; if (rp != 3 || mp != 2) begin failures++; $display("FAIL wen_pulses got=%0d/%0d want=3/2", rp, mp); end
    checks++; if (rom_words !== 4'd3 || ram_words !== 4'd2) begin failures++; $display("FAIL load_words got=%0d/%0d want=3/2", rom_words, ram_words); end
    checks++; if (upg_rst !== 1'b1 || load_busy !== 1'b0) begin failures++; $display("FAIL done_exit got upg=%b busy=%b want 1 0", upg_rst, load_busy); end
    for (int i = 0; i < DRN; i++) begin
      step(0, 1'($urandom), ADDR_W'($urandom), 0);
      checks++; if (cpu_rst !== (i < DRN - 1)) begin failures++; $display("FAIL post_done_cpu_rst cyc=%0d got=%b want=%b", i, cpu_rst, i < DRN - 1); end
      checks++; if (smp_rom_wen || smp_ram_wen || rom_words !== 4'd3 || ram_words !== 4'd2) begin failures++; $display("FAIL drain_hold cyc=%0d wen=%b%b words=%0d/%0d want 00 3/2", i, smp_rom_wen, smp_ram_wen, rom_words, ram_words); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    step(1, 0, '0, 0);
    while (load_busy === 1'b1 && n < 200) begin
      step(0, 0, '0, 0);
      n++;
    end
    checks++; if (n != TMO - 1) begin failures++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO - 1); end
    checks++; if (err_timeout !== 1'b1 || upg_rst !== 1'b1) begin failures++; $display("FAIL timeout_flag got err=%b upg=%b want 1 1", err_timeout, upg_rst); end
    for (int i = 0; i < DRN; i++) step(0, 0, '0, 0);
    checks++; if (cpu_rst !== 1'b0 || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got cpu=%b err=%b want 0 1", cpu_rst, err_timeout); end
    step(1, 0, '0, 0);
    checks++; if (err_timeout !== 1'b0 || load_busy !== 1'b1) begin failures++; $display("FAIL rearm_clear got err=%b busy=%b want 0 1", err_timeout, load_busy); end
  endtask

  task automatic test_write_at_limit();
    for (int i = 0; i < TMO - 2; i++) step(0, 0, '0, 0);
    step(0, 1, ADDR_W'(5), 0);
    checks++; if (load_busy !== 1'b1 || err_timeout !== 1'b0 || rom_words !== 4'd1) begin failures++; $display("FAIL limit_write got busy=%b err=%b rom=%0d want 1 0 1", load_busy, err_timeout, rom_words); end
    for (int i = 0; i < TMO - 2; i++) step(0, 0, '0, 0);
    checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL limit_continue got busy=%b want 1", load_busy); end
    step(0, 1, ADDR_W'(16'h4010), 1);
    checks++; if (ram_words !== 4'd1 || rom_words !== 4'd1 || load_busy !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL wen_done got ram=%0d rom=%0d busy=%b err=%b want 1 1 0 0", ram_words, rom_words, load_busy, err_timeout); end
    for (int i = 0; i < DRN; i++) step(0, 0, '0, 0);
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, ADDR_W'($urandom), 1'($urandom));
      checks++; if (smp_rom_wen || smp_ram_wen || int'(rom_words) != 1 || int'(ram_words) != 1 || load_busy !== 1'b0) begin failures++; $display("FAIL run_ignore cyc=%0d wen=%b%b words=%0d/%0d busy=%b want 00 1/1 0", i, smp_rom_wen, smp_ram_wen, rom_words, ram_words, load_busy); end
    end
    step(1, 0, '0, 0);
    step(0, 1, ADDR_W'(1), 0);
    step(0, 1, ADDR_W'(2), 0);
    step(1, 1, ADDR_W'(3), 0);
    checks++; if (rom_words !== 4'd3 || load_busy !== 1'b1 || upg_rst !== 1'b0) begin failures++; $display("FAIL start_in_load got rom=%0d busy=%b upg=%b want 3 1 0", rom_words, load_busy, upg_rst); end
    step(0, 0, '0, 1);
    for (int i = 0; i < DRN; i++) step(0, 0, '0, 0);
  endtask

  task automatic test_saturation();
    step(1, 0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, ADDR_W'($urandom_range(0, 16'h3fff)), 0);
      checks++; if (int'(rom_words) != ((i + 1 < MAXC) ? i + 1 : MAXC)) begin failures++; $display("FAIL sat_rom cyc=%0d got=%0d want=%0d", i, rom_words, (i + 1 < MAXC) ? i + 1 : MAXC); end
    end
    checks++; if (ram_words !== 4'd0) begin failures++; $display("FAIL sat_ram got=%0d want=0", ram_words); end
  endtask

  task automatic test_reset_mid_load();
    upg_wen = 1'b1; upg_adr = '0; upg_done = 1'b0; start_pg = 1'b0;
    #1;
    checks++; if (rom_wen !== 1'b1) begin failures++; $display("FAIL pre_reset_wen got=%b want=1", rom_wen); end
    rst_n = 1'b0;
    #1;
    checks++; if (rom_wen !== 1'b0 || ram_wen !== 1'b0) begin failures++; $display("FAIL reset_wen_drop got=%b%b want=00", rom_wen, ram_wen); end
    checks++; if (rom_words !== '0 || ram_words !== '0 || err_timeout !== 1'b0) begin failures++; $display("FAIL reset_clear got=%0d/%0d err=%b want 0/0 0", rom_words, ram_words, err_timeout); end
    checks++; if (load_busy !== 1'b0 || upg_rst !== 1'b1 || cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_regs got busy=%b upg=%b cpu=%b want 0 1 1", load_busy, upg_rst, cpu_rst); end
    upg_wen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DRN; i++) step(0, 0, '0, 0);
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL reset_drain_end got=%b want=0", cpu_rst); end
  endtask

  task automatic test_random();
    int wen_pct = 30;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: wen_pct = 0;
          1: wen_pct = 2;
          2: wen_pct = 30;
          default: wen_pct = 80;
        endcase
      end
      step($urandom_range(0, 4) == 0, $urandom_range(0, 99) < wen_pct, ADDR_W'($urandom), $urandom_range(0, 59) == 0);
      checks++; if (smp_rom_wen !== exp_rom_wen || smp_ram_wen !== exp_ram_wen) begin failures++; $display("FAIL rnd_wen cyc=%0d got=%b%b want=%b%b", i, smp_rom_wen, smp_ram_wen, exp_rom_wen, exp_ram_wen); end
      checks++; if (upg_rst !== !m_loading || load_busy !== m_loading) begin failures++; $display("FAIL rnd_mode cyc=%0d got upg=%b busy=%b want %b %b", i, upg_rst, load_busy, !m_loading, m_loading); end
      checks++; if (cpu_rst !== (m_loading || m_drain > 0)) begin failures++; $display("FAIL rnd_cpu_rst cyc=%0d got=%b want=%b", i, cpu_rst, m_loading || m_drain > 0); end
      checks++; if (int'(rom_words) != m_rom || int'(ram_words) != m_ram) begin failures++; $display("FAIL rnd_words cyc=%0d got=%0d/%0d want=%0d/%0d", i, rom_words, ram_words, m_rom, m_ram); end
      checks++; if (err_timeout !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", i, err_timeout, m_err); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_pg = 1'b0; upg_wen = 1'b0; upg_adr = '0; upg_done = 1'b0;
    model_reset();
    test_reset();
    test_basic_load();
    test_timeout();
    test_write_at_limit();
    test_ignored();
    test_saturation();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
